// File: rtl/s3g_tx_arb.sv
// Two-requester round-robin front end for s3g_tx: captures one packet per grant,
// strobes the transmitter, and reports completion or a start timeout to the owner.
module s3g_tx_arb #(
    parameter int START_TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic [7:0]   len0,
    input  logic [127:0] data0,
    output logic         gnt0,
    output logic         done0,
    input  logic         req1,
    input  logic [7:0]   len1,
    input  logic [127:0] data1,
    output logic         gnt1,
    output logic         done1,
    input  logic         tx_busy,
    output logic         tx_packet_wr,
    output logic [7:0]   tx_payload_len,
    output logic [127:0] tx_bufs,
    output logic         timeout_err,
    output logic         len_err
);

    localparam int CNT_W = $clog2(START_TIMEOUT + 1);

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_ISSUE      = 2'd1;
    localparam logic [1:0] S_WAIT_START = 2'd2;
    localparam logic [1:0] S_WAIT_END   = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             last_grant;
    logic             owner;

    logic             any_req;
    logic             pick;
    logic [7:0]       sel_len;
    logic [127:0]     sel_data;
    logic             len_over;
    logic [7:0]       len_clamped;
    logic             cnt_hit;

    // On a tie the requester not served last wins; a lone request always wins.
    assign any_req     = req0 | req1;
    assign pick        = (req0 && req1) ? ~last_grant : req1;
    assign sel_len     = pick ? len1 : len0;
    assign sel_data    = pick ? data1 : data0;
    assign len_over    = (sel_len > 8'd16);
    assign len_clamped = len_over ? 8'd16 : sel_len;
    assign cnt_hit     = (cnt == CNT_W'(START_TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            cnt            <= '0;
            last_grant     <= 1'b1;
            owner          <= 1'b0;
            gnt0           <= 1'b0;
            gnt1           <= 1'b0;
            done0          <= 1'b0;
            done1          <= 1'b0;
            tx_packet_wr   <= 1'b0;
            timeout_err    <= 1'b0;
            len_err        <= 1'b0;
            tx_payload_len <= '0;
            tx_bufs        <= '0;
        end else begin
            gnt0         <= 1'b0;
            gnt1         <= 1'b0;
            done0        <= 1'b0;
            done1        <= 1'b0;
            tx_packet_wr <= 1'b0;
            timeout_err  <= 1'b0;
            len_err      <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (any_req && !tx_busy) begin
                        owner          <= pick;
                        last_grant     <= pick;
                        gnt0           <= ~pick;
                        gnt1           <= pick;
                        tx_payload_len <= len_clamped;
                        tx_bufs        <= sel_data;
                        len_err        <= len_over;
                        state          <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    tx_packet_wr <= 1'b1;
                    cnt          <= '0;
                    state        <= S_WAIT_START;
                end
                S_WAIT_START: begin
                    // Busy seen while the strobe is still out predates this packet.
                    if (tx_busy && !tx_packet_wr) begin
                        state <= S_WAIT_END;
                    end else if (cnt_hit) begin
                        timeout_err <= 1'b1;
                        done0       <= ~owner;
                        done1       <= owner;
                        state       <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT_END: begin
                    if (!tx_busy) begin
                        done0 <= ~owner;
                        done1 <= owner;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
